ansi_key_decoder: RTL and testbench

//  Input-side counterpart of the ANSI terminal driver. The driver emits ESC/CSI

---
 rtl/ansi_key_pkg.sv | 67 ++++++
 rtl/csi_param_acc.sv | 37 +++
 rtl/ansi_key_decoder.sv | 181 ++++++++++++++++++
 tb/tb_ansi_key_decoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ansi_key_pkg.sv
`default_nettype none
// ============================================================================
// Module : ansi_key_pkg
// Brief  : Key event codes, byte constants, FSM states and final-byte decode.
// Rev    : 1.0
// ============================================================================
package ansi_key_pkg;

    typedef enum logic [3:0] {
        KEY_NONE    = 4'd0,
        KEY_CHAR    = 4'd1,
        KEY_UP      = 4'd2,
        KEY_DOWN    = 4'd3,
        KEY_RIGHT   = 4'd4,
        KEY_LEFT    = 4'd5,
        KEY_HOME    = 4'd6,
        KEY_END     = 4'd7,
        KEY_DEL     = 4'd8,
        KEY_PGUP    = 4'd9,
        KEY_PGDN    = 4'd10,
        KEY_ESC     = 4'd11,
        KEY_ALT     = 4'd12,
        KEY_CPR     = 4'd13,
        KEY_UNKNOWN = 4'd15
    } key_code_t;

    localparam logic [7:0] c_esc      = 8'h1B;
    localparam logic [7:0] c_lbracket = 8'h5B;
    localparam logic [7:0] c_semi     = 8'h3B;
    localparam logic [7:0] c_tilde    = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ESC    = 2'd1,
        ST_CSI_P0 = 2'd2,
        ST_CSI_P1 = 2'd3
    } state_t;

    // CPR is only meaningful once a second parameter has been opened.
    function automatic key_code_t csi_final_decode(input logic [7:0] b,
                                                   input logic [7:0] p0,
                                                   input logic       in_p1);
        key_code_t code;
        code = KEY_UNKNOWN;
        case (b)
            8'h41: code = KEY_UP;
            8'h42: code = KEY_DOWN;
            8'h43: code = KEY_RIGHT;
            8'h44: code = KEY_LEFT;
            8'h48: code = KEY_HOME;
            8'h46: code = KEY_END;
            8'h52: code = in_p1 ? KEY_CPR : KEY_UNKNOWN;
            c_tilde: begin
                case (p0)
                    8'd3:    code = KEY_DEL;
                    8'd5:    code = KEY_PGUP;
                    8'd6:    code = KEY_PGDN;
                    default: code = KEY_UNKNOWN;
                endcase
            end
            default: code = KEY_UNKNOWN;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csi_param_acc.sv
`default_nettype none
// ============================================================================
// Module : csi_param_acc
// Brief  : Saturating 8-bit decimal accumulator for one CSI parameter.
// Rev    : 1.0
// ============================================================================
module csi_param_acc #(
    parameter int PARAM_MAX = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       digit_stb,
    input  logic [3:0] digit,
    output logic [7:0] value
);

    logic [7:0]  r_value;
    logic [11:0] w_next;

    // 255*10+9 fits in 12 bits, so the clamp sees the true value.
    assign w_next = ({4'd0, r_value} * 12'd10) + {8'd0, digit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= 8'd0;
        end else if (clr) begin
            r_value <= 8'd0;
        end else if (digit_stb) begin
            r_value <= (w_next > 12'(PARAM_MAX)) ? 8'(PARAM_MAX) : w_next[7:0];
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/ansi_key_decoder.sv
`default_nettype none
// ============================================================================
// Module : ansi_key_decoder
// Brief  : Parses a raw keyboard byte stream (ESC/CSI) into key events.
// Rev    : 1.0
// ============================================================================
module ansi_key_decoder
    import ansi_key_pkg::*;
#(
    parameter int ESC_TIMEOUT = 4,
    parameter int PARAM_MAX   = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] inp,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [7:0] key_char,
    output logic [7:0] key_p0,
    output logic [7:0] key_p1,
    output logic [7:0] err_count
);

    localparam int TW = $clog2(ESC_TIMEOUT + 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [TW-1:0] r_timer;
    logic        r_key_valid;
    key_code_t   r_key_code;
    logic [7:0]  r_key_char;
    logic [7:0]  r_key_p0;
    logic [7:0]  r_key_p1;
    logic [7:0]  r_err_count;

    logic        w_byte;
    logic        w_is_digit;
    logic        w_is_final;
    logic        w_timeout;
    logic        w_evt;
    key_code_t   w_code;
    logic [7:0]  w_char;
    logic        w_csi;
    logic [7:0]  w_p0;
    logic [7:0]  w_p1;

    assign w_byte     = (inp != 8'h00);
    assign w_is_digit = (inp >= 8'h30) && (inp <= 8'h39);
    assign w_is_final = (inp >= 8'h40) && (inp <= 8'h7E);
    // Fires on the idle cycle that brings the count up to ESC_TIMEOUT.
    assign w_timeout  = !w_byte && (r_state != ST_IDLE) && (r_timer >= TW'(ESC_TIMEOUT - 1));

    csi_param_acc #(.PARAM_MAX(PARAM_MAX)) u_acc_p0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       ((r_state == ST_ESC) && (inp == c_lbracket)),
        .digit_stb ((r_state == ST_CSI_P0) && w_is_digit),
        .digit     (inp[3:0]),
        .value     (w_p0)
    );

    csi_param_acc #(.PARAM_MAX(PARAM_MAX)) u_acc_p1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       ((r_state == ST_ESC) && (inp == c_lbracket)),
        .digit_stb ((r_state == ST_CSI_P1) && w_is_digit),
        .digit     (inp[3:0]),
        .value     (w_p1)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_evt       = 1'b0;
        w_code      = KEY_NONE;
        w_char      = 8'h00;
        w_csi       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_byte) begin
                    if (inp == c_esc) begin
                        w_state_nxt = ST_ESC;
                    end else begin
                        w_evt  = 1'b1;
                        w_code = KEY_CHAR;
                        w_char = inp;
                    end
                end
            end
            ST_ESC: begin
                if (w_byte) begin
                    if (inp == c_lbracket) begin
                        w_state_nxt = ST_CSI_P0;
                    end else if (inp == c_esc) begin
                        w_evt  = 1'b1;
                        w_code = KEY_ESC;
                        w_char = c_esc;
                    end else begin
                        w_evt       = 1'b1;
                        w_code      = KEY_ALT;
                        w_char      = inp;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_evt       = 1'b1;
                    w_code      = KEY_ESC;
                    w_char      = c_esc;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CSI_P0, ST_CSI_P1: begin
                w_csi = 1'b1;
                if (w_byte) begin
                    if (w_is_digit) begin
                        w_state_nxt = r_state;
                    end else if ((inp == c_semi) && (r_state == ST_CSI_P0)) begin
                        w_state_nxt = ST_CSI_P1;
                    end else if (w_is_final) begin
                        w_evt       = 1'b1;
                        w_code      = csi_final_decode(inp, w_p0, r_state == ST_CSI_P1);
                        w_char      = (w_code == KEY_UNKNOWN) ? inp : 8'h00;
                        w_state_nxt = ST_IDLE;
                    end else if (inp == c_esc) begin
                        w_evt       = 1'b1;
                        w_code      = KEY_UNKNOWN;
                        w_char      = c_esc;
                        w_state_nxt = ST_ESC;
                    end else begin
                        w_evt       = 1'b1;
                        w_code      = KEY_UNKNOWN;
                        w_char      = inp;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_evt       = 1'b1;
                    w_code      = KEY_UNKNOWN;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= KEY_NONE;
            r_key_char  <= 8'h00;
            r_key_p0    <= 8'h00;
            r_key_p1    <= 8'h00;
            r_err_count <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_key_valid <= w_evt;
            if ((r_state == ST_IDLE) || w_byte) begin
                r_timer <= '0;
            end else if (r_timer != TW'(ESC_TIMEOUT)) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_evt) begin
                r_key_code <= w_code;
                r_key_char <= w_char;
                r_key_p0   <= w_csi ? w_p0 : 8'h00;
                r_key_p1   <= w_csi ? w_p1 : 8'h00;
                if ((w_code == KEY_UNKNOWN) && (r_err_count != 8'hFF)) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_char  = r_key_char;
    assign key_p0    = r_key_p0;
    assign key_p1    = r_key_p1;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_ansi_key_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_ansi_key_decoder
// Brief  : Directed self-checking bench for ansi_key_decoder.
// Rev    : 1.0
// ============================================================================
module tb_ansi_key_decoder;
    import ansi_key_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] inp;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] key_char;
    logic [7:0] key_p0;
    logic [7:0] key_p1;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    ansi_key_decoder #(.ESC_TIMEOUT(4), .PARAM_MAX(255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inp       (inp),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_char  (key_char),
        .key_p0    (key_p0),
        .key_p1    (key_p1),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one byte at a negedge; the event it causes is visible at the next negedge.
    task automatic put(input logic [7:0] b);
        inp = b;
        @(negedge clk);
    endtask

    task automatic put_quiet(input string tag, input logic [7:0] b);
        put(b);
        check(tag, key_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        inp   = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_valid", key_valid, 1'b0);
        check("rst_code",  key_code,  4'd0);
        check("rst_char",  key_char,  8'h00);
        check("rst_p0",    key_p0,    8'h00);
        check("rst_p1",    key_p1,    8'h00);
        check("rst_err",   err_count, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Printable char
        put(8'h61);
        check("char_valid", key_valid, 1'b1);
        check("char_code",  key_code,  KEY_CHAR);
        check("char_byte",  key_char,  8'h61);
        put(8'h00);
        check("char_pulse", key_valid, 1'b0);
        check("char_hold",  key_code,  KEY_CHAR);

        // Arrow up, back-to-back
        put_quiet("up_esc", 8'h1B);
        put_quiet("up_lb",  8'h5B);
        put(8'h41);
        check("up_valid", key_valid, 1'b1);
        check("up_code",  key_code,  KEY_UP);
        check("up_p0",    key_p0,    8'd0);
        check("up_p1",    key_p1,    8'd0);
        put_quiet("up_after", 8'h00);

        // Cursor position report ESC[12;40R
        put_quiet("cpr_esc", 8'h1B);
        put_quiet("cpr_lb",  8'h5B);
        put_quiet("cpr_1",   8'h31);
        put_quiet("cpr_2",   8'h32);
        put_quiet("cpr_sc",  8'h3B);
        put_quiet("cpr_4",   8'h34);
        put_quiet("cpr_0",   8'h30);
        put(8'h52);
        check("cpr_valid", key_valid, 1'b1);
        check("cpr_code",  key_code,  KEY_CPR);
        check("cpr_row",   key_p0,    8'd12);
        check("cpr_col",   key_p1,    8'd40);
        put(8'h00);

        // Saturating parameter ESC[999~
        put_quiet("sat_esc", 8'h1B);
        put_quiet("sat_lb",  8'h5B);
        put_quiet("sat_9a",  8'h39);
        put_quiet("sat_9b",  8'h39);
        put_quiet("sat_9c",  8'h39);
        put(8'h7E);
        check("sat_valid", key_valid, 1'b1);
        check("sat_code",  key_code,  KEY_UNKNOWN);
        check("sat_p0",    key_p0,    8'd255);
        check("sat_err",   err_count, 8'd1);
        put(8'h00);

        // Bare ESC closed out after four idle cycles
        put_quiet("to_esc", 8'h1B);
        put_quiet("to_idle1", 8'h00);
        put_quiet("to_idle2", 8'h00);
        put_quiet("to_idle3", 8'h00);
        put(8'h00);
        check("to_valid", key_valid, 1'b1);
        check("to_code",  key_code,  KEY_ESC);
        put_quiet("to_after", 8'h00);

        // ESC ESC [ B -> KEY_ESC then KEY_DOWN
        put_quiet("ee_esc1", 8'h1B);
        put(8'h1B);
        check("ee_valid1", key_valid, 1'b1);
        check("ee_code1",  key_code,  KEY_ESC);
        put_quiet("ee_lb", 8'h5B);
        put(8'h42);
        check("ee_valid2", key_valid, 1'b1);
        check("ee_code2",  key_code,  KEY_DOWN);
        put(8'h00);

        // Alt+x
        put_quiet("alt_esc", 8'h1B);
        put(8'h78);
        check("alt_code", key_code, KEY_ALT);
        check("alt_char", key_char, 8'h78);

        // Delete ESC[3~
        put_quiet("del_esc", 8'h1B);
        put_quiet("del_lb",  8'h5B);
        put_quiet("del_3",   8'h33);
        put(8'h7E);
        check("del_valid", key_valid, 1'b1);
        check("del_code",  key_code,  KEY_DEL);
        check("del_p0",    key_p0,    8'd3);
        check("del_err",   err_count, 8'd1);

        // Reset in the middle of ESC[3 discards the sequence
        put_quiet("mr_esc", 8'h1B);
        put_quiet("mr_lb",  8'h5B);
        put_quiet("mr_3",   8'h33);
        inp   = 8'h00;
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_valid", key_valid, 1'b0);
        check("mr_code",  key_code,  4'd0);
        check("mr_err",   err_count, 8'd0);
        rst_n = 1'b1;
        put(8'h7E);
        check("mr_tvalid", key_valid, 1'b1);
        check("mr_tcode",  key_code,  KEY_CHAR);
        check("mr_tchar",  key_char,  8'h7E);
        put(8'h00);

        // Partial CSI times out as unknown
        put_quiet("ct_esc", 8'h1B);
        put_quiet("ct_lb",  8'h5B);
        put_quiet("ct_i1",  8'h00);
        put_quiet("ct_i2",  8'h00);
        put_quiet("ct_i3",  8'h00);
        put(8'h00);
        check("ct_valid", key_valid, 1'b1);
        check("ct_code",  key_code,  KEY_UNKNOWN);
        check("ct_err",   err_count, 8'd1);

        // err_count sticks at 255
        for (int i = 0; i < 300; i++) begin
            put(8'h1B);
            put(8'h5B);
            put(8'h5A);
        end
        check("sat_err_code", key_code,  KEY_UNKNOWN);
        check("sat_err_char", key_char,  8'h5A);
        check("sat_err_cnt",  err_count, 8'd255);
        put(8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
